// File: rtl/pio_hs_pkg.sv
// Shared encodings for the software/hardware PIO handshake: the software
// command word, the hardware status word and the controller state set.
package pio_hs_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_START = 2'b10,
        CMD_READ  = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        STAT_READY = 2'b00,
        STAT_ACK   = 2'b01,
        STAT_BUSY  = 2'b10,
        STAT_DONE  = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int WORD_W = 32;

endpackage

// File: rtl/pio_handshake_ctrl.sv
// Four-phase PIO handshake controller: software loads key/message words,
// launches the engine, and reads back the result words one at a time.
module pio_handshake_ctrl
    import pio_hs_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_OUT = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [WORD_W-1:0]     to_hw_port,
    input  logic [1:0]            to_hw_sig,
    output logic [WORD_W-1:0]     to_sw_port,
    output logic [1:0]            to_sw_sig,
    output logic [127:0]          key_out,
    output logic [127:0]          msg_out,
    output logic                  eng_start,
    input  logic                  eng_done,
    input  logic [127:0]          eng_result
);

    localparam int WR_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int RD_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [WR_W-1:0] WR_LAST = WR_W'(N_IN - 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(N_OUT - 1);

    cmd_t              hw_sig_q;
    logic [WORD_W-1:0] hw_port_q;
    state_t            state;
    logic [WORD_W-1:0] buffer [N_IN];
    logic [WORD_W-1:0] result [N_OUT];
    logic              result_valid;
    logic [WR_W-1:0]   wr_idx;
    logic [RD_W-1:0]   rd_idx;

    // Buffer is only written from IDLE, so the key/message stay frozen during RUN.
    assign key_out = {buffer[0], buffer[1], buffer[2], buffer[3]};
    assign msg_out = {buffer[4], buffer[5], buffer[6], buffer[7]};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            hw_sig_q     <= CMD_IDLE;
            hw_port_q    <= '0;
            state        <= ST_IDLE;
            to_sw_sig    <= STAT_READY;
            to_sw_port   <= '0;
            eng_start    <= 1'b0;
            result_valid <= 1'b0;
            wr_idx       <= '0;
            rd_idx       <= '0;
            for (int i = 0; i < N_IN; i++) begin
                buffer[i] <= '0;
            end
            for (int i = 0; i < N_OUT; i++) begin
                result[i] <= '0;
            end
        end else begin
            hw_sig_q  <= cmd_t'(to_hw_sig);
            hw_port_q <= to_hw_port;
            eng_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    case (hw_sig_q)
                        CMD_WRITE: begin
                            buffer[wr_idx] <= hw_port_q;
                            wr_idx         <= (wr_idx == WR_LAST) ? '0 : wr_idx + 1'b1;
                            state          <= ST_ACK;
                            to_sw_sig      <= STAT_ACK;
                        end
                        CMD_READ: begin
                            if (result_valid) begin
                                to_sw_port <= result[rd_idx];
                                rd_idx     <= (rd_idx == RD_LAST) ? '0 : rd_idx + 1'b1;
                                state      <= ST_ACK;
                                to_sw_sig  <= STAT_ACK;
                            end
                        end
                        CMD_START: begin
                            eng_start    <= 1'b1;
                            result_valid <= 1'b0;
                            state        <= ST_RUN;
                            to_sw_sig    <= STAT_BUSY;
                        end
                        default: begin
                        end
                    endcase
                end

                ST_ACK: begin
                    if (hw_sig_q == CMD_IDLE) begin
                        state     <= ST_IDLE;
                        to_sw_sig <= STAT_READY;
                    end
                end

                // Software commands are deliberately ignored while the engine runs.
                ST_RUN: begin
                    if (eng_done) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            result[i] <= eng_result[127 - 32*i -: 32];
                        end
                        result_valid <= 1'b1;
                        wr_idx       <= '0;
                        rd_idx       <= '0;
                        state        <= ST_DONE;
                        to_sw_sig    <= STAT_DONE;
                    end
                end

                ST_DONE: begin
                    if (hw_sig_q == CMD_IDLE) begin
                        state     <= ST_IDLE;
                        to_sw_sig <= STAT_READY;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    to_sw_sig <= STAT_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_handshake_ctrl.sv
// Randomised scoreboard bench for pio_handshake_ctrl against a word-level
// model of the software-visible buffer, result and index behaviour.
module tb_pio_handshake_ctrl;
    import pio_hs_pkg::*;

    logic         clk_clk = 1'b0;
    logic         reset_reset;
    logic [31:0]  to_hw_port;
    logic [1:0]   to_hw_sig;
    logic [31:0]  to_sw_port;
    logic [1:0]   to_sw_sig;
    logic [127:0] key_out;
    logic [127:0] msg_out;
    logic         eng_start;
    logic         eng_done;
    logic [127:0] eng_result;

    pio_handshake_ctrl #(.N_IN(8), .N_OUT(4)) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .to_hw_port (to_hw_port),
        .to_hw_sig  (to_hw_sig),
        .to_sw_port (to_sw_port),
        .to_sw_sig  (to_sw_sig),
        .key_out    (key_out),
        .msg_out    (msg_out),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [1:0]   sig;
        logic [31:0]  port;
        logic [127:0] key;
        logic [127:0] msg;
        string        what;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] m_buf [8];
    logic [31:0] m_res [4];
    int          m_wr, m_rd;
    bit          m_rv;
    logic [31:0] m_port;

    logic [127:0] eng_value;
    int           eng_delay = 10;

    function automatic logic [127:0] model_key();
        return {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
    endfunction

    function automatic logic [127:0] model_msg();
        return {m_buf[4], m_buf[5], m_buf[6], m_buf[7]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_buf[i] = '0;
        for (int i = 0; i < 4; i++) m_res[i] = '0;
        m_wr = 0; m_rd = 0; m_rv = 0; m_port = '0;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] data);
        @(posedge clk_clk); #1;
        to_hw_sig  = cmd;
        to_hw_port = data;
    endtask

    task automatic push_exp(input logic [1:0] sig, input string what);
        exp_t e;
        e.sig = sig; e.port = m_port; e.key = model_key(); e.msg = model_msg(); e.what = what;
        exp_q.push_back(e);
    endtask

    // Issue WRITE or accepted READ, check two-cycle latency, hold, then release.
    task automatic handshake(input logic [1:0] cmd, input logic [31:0] data, input int hold);
        if (cmd == CMD_WRITE) begin
            m_buf[m_wr] = data;
            m_wr = (m_wr + 1) % 8;
            push_exp(STAT_ACK, "write_ack");
        end else begin
            m_port = m_res[m_rd];
            m_rd = (m_rd + 1) % 4;
            push_exp(STAT_ACK, "read_ack");
        end
        applyStimulus(cmd, data);
        repeat (2) @(negedge clk_clk);
        checkOutput("latency_pre", to_sw_sig, STAT_READY);
        @(negedge clk_clk);
        checkOutput("latency_ack", to_sw_sig, STAT_ACK);
        for (int i = 3; i < hold; i++) begin
            @(negedge clk_clk);
            checkOutput("ack_hold_cmd", to_sw_sig, STAT_ACK);
        end
        applyStimulus(CMD_IDLE, $urandom);
        repeat (2) @(negedge clk_clk);
        checkOutput("ack_hold_idle", to_sw_sig, STAT_ACK);
        @(negedge clk_clk);
        checkOutput("ack_release", to_sw_sig, STAT_READY);
    endtask

    task automatic ignored_read();
        applyStimulus(CMD_READ, $urandom);
        repeat (4) begin
            @(negedge clk_clk);
            checkOutput("ignored_read_sig", to_sw_sig, STAT_READY);
            checkOutput("ignored_read_port", to_sw_port, m_port);
        end
        applyStimulus(CMD_IDLE, '0);
        repeat (2) @(negedge clk_clk);
    endtask

    task automatic do_read();
        if (m_rv) handshake(CMD_READ, $urandom, 3);
        else      ignored_read();
    endtask

    // START held through RUN to show that commands are ignored there.
    task automatic do_start(input logic [127:0] res, input int delay);
        int  starts, busy_cycles;
        bit  busy_seen, done_seen;
        starts = 0; busy_cycles = 0; busy_seen = 0; done_seen = 0;
        eng_value = res;
        eng_delay = delay;
        m_rv = 0;
        push_exp(STAT_DONE, "done");
        applyStimulus(CMD_START, $urandom);
        for (int c = 0; c < 300 && !done_seen; c++) begin
            @(negedge clk_clk);
            if (eng_start) starts++;
            if (to_sw_sig == STAT_BUSY) begin
                busy_seen = 1;
                busy_cycles++;
                checkOutput("key_stable", key_out, model_key());
            end else if (to_sw_sig == STAT_DONE) begin
                done_seen = 1;
            end else if (busy_seen) begin
                checkOutput("busy_held", to_sw_sig, STAT_BUSY);
            end
        end
        checkOutput("done_seen", done_seen, 1);
        checkOutput("busy_cycles", busy_cycles, delay + 1);
        checkOutput("eng_start_pulses", starts, 1);
        checkOutput("msg_stable", msg_out, model_msg());
        for (int i = 0; i < 4; i++) m_res[i] = res[127 - 32*i -: 32];
        m_rv = 1; m_wr = 0; m_rd = 0;
        applyStimulus(CMD_IDLE, '0);
        repeat (3) @(negedge clk_clk);
        checkOutput("done_release", to_sw_sig, STAT_READY);
    endtask

    // Engine: answers eng_start with eng_done after eng_delay cycles.
    initial begin
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clk_clk); #1;
            if (eng_start) begin
                repeat (eng_delay) @(posedge clk_clk);
                #1;
                eng_done = 1'b1;
                eng_result = eng_value;
                @(posedge clk_clk); #1;
                eng_done = 1'b0;
                eng_result = $urandom;
            end
        end
    end

    // Monitor: every entry into ACK or DONE must match the oldest expectation.
    initial begin
        logic [1:0] prev_sig;
        exp_t e;
        prev_sig = STAT_READY;
        forever begin
            @(negedge clk_clk);
            if (!reset_reset && to_sw_sig !== prev_sig &&
                (to_sw_sig == STAT_ACK || to_sw_sig == STAT_DONE)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_status: got %0d expected none", to_sw_sig);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({e.what, "_sig"}, to_sw_sig, e.sig);
                    checkOutput({e.what, "_port"}, to_sw_port, e.port);
                    checkOutput({e.what, "_key"}, key_out, e.key);
                    checkOutput({e.what, "_msg"}, msg_out, e.msg);
                end
            end
            prev_sig = to_sw_sig;
        end
    end

    initial begin
        logic [31:0] scen [8];
        bit busy_seen;
        scen = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C,
                 32'h3243F6A8, 32'h885A308D, 32'h313198A2, 32'hE0370734};

        reset_reset = 1'b1;
        to_hw_sig   = CMD_IDLE;
        to_hw_port  = '0;
        model_reset();
        repeat (3) @(posedge clk_clk);
        #1 reset_reset = 1'b0;
        @(negedge clk_clk);
        checkOutput("reset_sig", to_sw_sig, STAT_READY);
        checkOutput("reset_port", to_sw_port, 0);
        checkOutput("reset_start", eng_start, 0);
        checkOutput("reset_key", key_out, 0);
        checkOutput("reset_msg", msg_out, 0);

        ignored_read();

        foreach (scen[i]) handshake(CMD_WRITE, scen[i], 3);
        checkOutput("scen_key", key_out, 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C);
        checkOutput("scen_msg", msg_out, 128'h3243F6A8_885A308D_313198A2_E0370734);

        do_start(128'h3925841D_02DC09FB_DC118597_196A0B32, 10);
        repeat (5) do_read();
        checkOutput("read_wrap_port", to_sw_port, 32'h3925841D);

        handshake(CMD_WRITE, 32'hDEADBEEF, 5);
        handshake(CMD_WRITE, 32'h0BADF00D, 3);
        checkOutput("hold_write_key", key_out,
                    {32'hDEADBEEF, 32'h0BADF00D, 32'hABF71588, 32'h09CF4F3C});

        // Reset during RUN; the engine's late eng_done must be ignored.
        eng_value = {4{32'hA5A5A5A5}};
        eng_delay = 10;
        applyStimulus(CMD_START, '0);
        busy_seen = 0;
        for (int c = 0; c < 10 && !busy_seen; c++) begin
            @(negedge clk_clk);
            if (to_sw_sig == STAT_BUSY) busy_seen = 1;
        end
        checkOutput("abort_busy_seen", busy_seen, 1);
        @(posedge clk_clk); #1;
        reset_reset = 1'b1;
        to_hw_sig   = CMD_IDLE;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        model_reset();
        repeat (15) begin
            @(negedge clk_clk);
            checkOutput("abort_sig", to_sw_sig, STAT_READY);
        end
        checkOutput("abort_port", to_sw_port, 0);
        checkOutput("abort_key", key_out, 0);
        ignored_read();

        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op <= 1)      handshake(CMD_WRITE, $urandom, $urandom_range(3, 5));
            else if (op == 2) do_read();
            else              do_start({$urandom, $urandom, $urandom, $urandom},
                                       $urandom_range(1, 20));
        end
        checkOutput("final_key", key_out, model_key());
        checkOutput("final_msg", msg_out, model_msg());
        repeat (4) @(negedge clk_clk);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
